// File: rtl/op_window_streamer.sv
// op_window_streamer: turns a raster pixel stream into zero/constant padded
// WINDOW_SIZE x WINDOW_SIZE windows, optionally decimated by STRIDE.
//
// state | meaning
// IDLE  | first cycle after reset, no scan step
// SCAN  | scanning pad rows at top and image rows, reads on image positions
// FLUSH | bottom pad rows, windows still emitted, no reads
module op_window_streamer #(
  parameter int                WINDOW_SIZE = 3,
  parameter int                STRIDE      = 1,
  parameter int                DWIDTH      = 8,
  parameter int                IMG_WIDTH   = 720,
  parameter int                IMG_HEIGHT  = 540,
  parameter logic [DWIDTH-1:0] PAD_VALUE   = '0
) (
  input  logic                                      clock,
  input  logic                                      reset,
  output logic                                      fifo_in_rd_en,
  input  logic [DWIDTH-1:0]                         fifo_in_dout,
  input  logic                                      fifo_in_empty,
  output logic                                      fifo_out_wr_en,
  output logic [DWIDTH*WINDOW_SIZE*WINDOW_SIZE-1:0] fifo_out_din,
  input  logic                                      fifo_out_full,
  output logic [$clog2(IMG_WIDTH)-1:0]              out_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]             out_y,
  output logic                                      frame_done
);

  localparam int PAD     = WINDOW_SIZE / 2;
  localparam int PW      = IMG_WIDTH + 2 * PAD;
  localparam int PH      = IMG_HEIGHT + 2 * PAD;
  localparam int SXW     = $clog2(PW);
  localparam int SYW     = $clog2(PH);
  localparam int XW      = $clog2(IMG_WIDTH);
  localparam int YW      = $clog2(IMG_HEIGHT);
  localparam int NB      = DWIDTH * WINDOW_SIZE * WINDOW_SIZE;
  localparam int CX_LAST = ((IMG_WIDTH - 1) / STRIDE) * STRIDE;
  localparam int CY_LAST = ((IMG_HEIGHT - 1) / STRIDE) * STRIDE;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t            state_q;
  logic [SXW-1:0]    sx_q;
  logic [SYW-1:0]    sy_q;
  logic [DWIDTH-1:0] win_q [WINDOW_SIZE][WINDOW_SIZE];
  logic [DWIDTH-1:0] win_d [WINDOW_SIZE][WINDOW_SIZE];
  logic [DWIDTH-1:0] lb_q  [WINDOW_SIZE-1][PW];
  logic [DWIDTH-1:0] col_d [WINDOW_SIZE];
  logic [DWIDTH-1:0] pix_d;
  logic [NB-1:0]     din_d;
  logic [NB-1:0]     din_q;
  logic [XW-1:0]     out_x_q;
  logic [YW-1:0]     out_y_q;
  logic              wr_en_q;
  logic              frame_done_q;
  int                sx_i, sy_i, cx_i, cy_i, sx_d, sy_d;
  logic              is_pad, wr_due, last_win, step;

  // Position classification, step qualification and next window contents
  always_comb begin
    sx_i     = int'(sx_q);
    sy_i     = int'(sy_q);
    cx_i     = sx_i - 2 * PAD;
    cy_i     = sy_i - 2 * PAD;
    is_pad   = (sx_i < PAD) || (sx_i >= IMG_WIDTH + PAD) ||
               (sy_i < PAD) || (sy_i >= IMG_HEIGHT + PAD);
    wr_due   = (cx_i >= 0) && (cy_i >= 0) &&
               (cx_i % STRIDE == 0) && (cy_i % STRIDE == 0);
    last_win = (cx_i == CX_LAST) && (cy_i == CY_LAST);
    step     = !reset && (state_q != IDLE) &&
               (is_pad || !fifo_in_empty) && (!wr_due || !fifo_out_full);
    pix_d    = is_pad ? PAD_VALUE : fifo_in_dout;

    // new right-hand column: bottom row is the incoming pixel, rows above
    // come from the line buffer tails (one row older per buffer)
    col_d[WINDOW_SIZE-1] = pix_d;
    for (int k = 0; k < WINDOW_SIZE - 1; k++)
      col_d[WINDOW_SIZE-2-k] = lb_q[k][PW-1];

    for (int r = 0; r < WINDOW_SIZE; r++) begin
      for (int c = 0; c < WINDOW_SIZE - 1; c++)
        win_d[r][c] = win_q[r][c+1];
      win_d[r][WINDOW_SIZE-1] = col_d[r];
    end

    din_d = '0;
    for (int r = 0; r < WINDOW_SIZE; r++)
      for (int c = 0; c < WINDOW_SIZE; c++)
        din_d[(r*WINDOW_SIZE+c)*DWIDTH +: DWIDTH] = win_d[r][c];

    sx_d = (sx_i == PW - 1) ? 0 : sx_i + 1;
    sy_d = (sx_i != PW - 1) ? sy_i : ((sy_i == PH - 1) ? 0 : sy_i + 1);
  end

  assign fifo_in_rd_en  = step && !is_pad;
  assign fifo_out_wr_en = wr_en_q;
  assign fifo_out_din   = din_q;
  assign out_x          = out_x_q;
  assign out_y          = out_y_q;
  assign frame_done     = frame_done_q;

  // Line buffers shift one column per step; stale contents are never used
  // because the top pad rows refill them before any window completes
  always_ff @(posedge clock) begin
    if (step) begin
      lb_q[0][0] <= pix_d;
      for (int k = 1; k < WINDOW_SIZE - 1; k++)
        lb_q[k][0] <= lb_q[k-1][PW-1];
      for (int k = 0; k < WINDOW_SIZE - 1; k++)
        for (int i = 1; i < PW; i++)
          lb_q[k][i] <= lb_q[k][i-1];
    end
  end

  // Scan FSM, window register and registered write outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      sx_q         <= '0;
      sy_q         <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      din_q        <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      for (int r = 0; r < WINDOW_SIZE; r++)
        for (int c = 0; c < WINDOW_SIZE; c++)
          win_q[r][c] <= '0;
    end else begin
      wr_en_q      <= step && wr_due;
      frame_done_q <= step && wr_due && last_win;
      if (step && wr_due) begin
        din_q   <= din_d;
        out_x_q <= XW'(cx_i);
        out_y_q <= YW'(cy_i);
      end
      if (step)
        for (int r = 0; r < WINDOW_SIZE; r++)
          for (int c = 0; c < WINDOW_SIZE; c++)
            win_q[r][c] <= win_d[r][c];
      case (state_q)
        IDLE: state_q <= SCAN;
        default: begin
          if (step) begin
            sx_q    <= SXW'(sx_d);
            sy_q    <= SYW'(sy_d);
            state_q <= (sy_d >= IMG_HEIGHT + PAD) ? FLUSH : SCAN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_window_streamer.sv
// Bench for op_window_streamer: two 4x4 instances (stride 1 / pad 0 and
// stride 2 / pad 255), queue-based source FIFO, scoreboard fed by a
// coordinate-level window model.
module tb_op_window_streamer;

  localparam int W  = 3;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int NB = 72;

  typedef struct packed {
    logic          fd;
    logic [7:0]    y;
    logic [7:0]    x;
    logic [NB-1:0] din;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          src_empty = 1'b1;
  logic [7:0]    src_dout = 8'h00;
  logic          out_full = 1'b0;
  int            sel = 0;

  logic          rd0, rd1, wr0, wr1, fd0, fd1;
  logic          empty0, empty1, full0, full1;
  logic [NB-1:0] din0, din1;
  logic [1:0]    x0, x1, y0, y1;

  logic          aw, afd, rd_s;
  logic [NB-1:0] ad;
  logic [1:0]    ax, ay;
  rec_t          a_rec, e_rec;

  int   n_chk = 0, n_pass = 0, cyc = 0;
  int   n_rd_hold = 0, n_wr_bad = 0, n_wr_empty = 0, hold_left = 0;
  bit   arm = 0, hold_fired = 0, rand_empty = 0;
  int   stride = 1, padv = 0;
  int   frame_pix [16];
  int   p2 [16];
  logic [7:0] src_q [$];
  rec_t exp_q [$];
  rec_t log_q [$];
  int   fd_cyc [$];

  assign empty0 = (sel == 0) ? src_empty : 1'b1;
  assign empty1 = (sel == 1) ? src_empty : 1'b1;
  assign full0  = (sel == 0) ? out_full : 1'b0;
  assign full1  = (sel == 1) ? out_full : 1'b0;

  op_window_streamer #(.WINDOW_SIZE(3), .STRIDE(1), .DWIDTH(8), .IMG_WIDTH(IW),
                       .IMG_HEIGHT(IH), .PAD_VALUE(8'd0)) dut0 (
    .clock(clk), .reset(rst),
    .fifo_in_rd_en(rd0), .fifo_in_dout(src_dout), .fifo_in_empty(empty0),
    .fifo_out_wr_en(wr0), .fifo_out_din(din0), .fifo_out_full(full0),
    .out_x(x0), .out_y(y0), .frame_done(fd0));

  op_window_streamer #(.WINDOW_SIZE(3), .STRIDE(2), .DWIDTH(8), .IMG_WIDTH(IW),
                       .IMG_HEIGHT(IH), .PAD_VALUE(8'd255)) dut1 (
    .clock(clk), .reset(rst),
    .fifo_in_rd_en(rd1), .fifo_in_dout(src_dout), .fifo_in_empty(empty1),
    .fifo_out_wr_en(wr1), .fifo_out_din(din1), .fifo_out_full(full1),
    .out_x(x1), .out_y(y1), .frame_done(fd1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [NB-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // reference: every centre on the stride grid, element (r,c) is the image
  // pixel at (cx+c-1, cy+r-1) or the pad constant when outside the frame
  function automatic void push_frame();
    rec_t r;
    int   xx, yy, v;
    for (int i = 0; i < 16; i++) src_q.push_back(8'(frame_pix[i]));
    for (int cy = 0; cy < IH; cy += stride)
      for (int cx = 0; cx < IW; cx += stride) begin
        r = '0;
        for (int rr = 0; rr < W; rr++)
          for (int cc = 0; cc < W; cc++) begin
            xx = cx + cc - 1;
            yy = cy + rr - 1;
            v  = (xx < 0 || xx >= IW || yy < 0 || yy >= IH) ? padv : frame_pix[yy*IW+xx];
            r.din[(rr*W+cc)*8 +: 8] = 8'(v);
          end
        r.x  = 8'(cx);
        r.y  = 8'(cy);
        r.fd = (cx + stride >= IW) && (cy + stride >= IH);
        exp_q.push_back(r);
      end
  endfunction

  // monitor: pops the scoreboard on every write of the selected instance
  always @(negedge clk) begin
    aw  = sel ? wr1 : wr0;
    afd = sel ? fd1 : fd0;
    ad  = sel ? din1 : din0;
    ax  = sel ? x1 : x0;
    ay  = sel ? y1 : y0;
    if (aw) begin
      a_rec = {afd, {6'b0, ay}, {6'b0, ax}, ad};
      log_q.push_back(a_rec);
      if (out_full) n_wr_bad++;
      if (src_empty) n_wr_empty++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got %h expected no write", a_rec);
      end else begin
        e_rec = exp_q.pop_front();
        chk("window", 128'(a_rec), 128'(e_rec));
      end
      if (arm && ax == 2'd1 && ay == 2'd1) begin
        hold_left  = 10;
        arm        = 0;
        hold_fired = 1;
      end
      if (afd) fd_cyc.push_back(cyc);
    end else if (afd) begin
      n_chk++;
      $display("FAIL frame_done_alone: got frame_done=1 expected 0 without write");
    end
  end

  // first-word-fall-through source and sink back-pressure driver
  always begin
    @(negedge clk);
    #2;
    src_empty = (src_q.size() == 0) || (rand_empty && ($urandom_range(0, 2) == 0));
    src_dout  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    out_full  = (hold_left > 0);
    if (hold_left > 0) hold_left--;
    #1;
    rd_s = sel ? rd1 : rd0;
    if (rst) chk("rd_en_in_reset", 128'({rd1, rd0}), 128'(0));
    if (out_full && rd_s) n_rd_hold++;
    @(posedge clk);
    if (rd_s) begin
      if (src_empty) begin
        n_chk++;
        $display("FAIL read_from_empty: got rd_en=1 expected 0");
      end else void'(src_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_fd(input int n, input int budget, input string name);
    int t = fd_cyc.size() + n;
    int k = 0;
    while (fd_cyc.size() < t && k < budget) begin
      tick(1);
      k++;
    end
    if (fd_cyc.size() < t) chk({name, "_timeout"}, 128'(fd_cyc.size()), 128'(t));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    hold_left = 0;
    arm       = 0;
    src_q.delete();
    exp_q.delete();
    tick(2);
    chk("reset_outputs", 128'({sel ? fd1 : fd0, sel ? y1 : y0, sel ? x1 : x0,
                                sel ? wr1 : wr0, sel ? din1 : din0}), 128'(0));
    rst = 1'b0;
    tick(1);
    chk("no_write_after_reset", 128'(sel ? wr1 : wr0), 128'(0));
  endtask

  initial begin
    int base, fbase, nwin;
    int tx [4], ty [4], tf [4];
    tx = '{0, 2, 0, 2};
    ty = '{0, 0, 2, 2};
    tf = '{0, 0, 0, 1};
    for (int s = 0; s < 2; s++) begin
      sel    = s;
      stride = s ? 2 : 1;
      padv   = s ? 255 : 0;
      nwin   = s ? 4 : 16;
      do_reset();

      // two back-to-back unstalled frames
      base  = log_q.size();
      fbase = fd_cyc.size();
      for (int i = 0; i < 16; i++) frame_pix[i] = i + 1;
      push_frame();
      for (int i = 0; i < 16; i++) begin
        p2[i] = int'($urandom_range(0, 255));
        frame_pix[i] = p2[i];
      end
      push_frame();
      wait_fd(2, 400, "two_frames");
      chk("two_frames_writes", 128'(log_q.size() - base), 128'(2 * nwin));
      chk("two_frames_leftover", 128'(exp_q.size()), 128'(0));
      if (fd_cyc.size() >= fbase + 2)
        chk("frame_period", 128'(fd_cyc[fbase+1] - fd_cyc[fbase]), 128'(36));
      if (log_q.size() >= base + 2 * nwin) begin
        chk("first_window", 128'(log_q[base].din),
            128'(pack9(padv, padv, padv, padv, 1, 2, padv, 5, 6)));
        chk("frame2_first_window", 128'(log_q[base+nwin].din),
            128'(pack9(padv, padv, padv, padv, p2[0], p2[1], padv, p2[4], p2[5])));
        if (sel == 0) begin
          chk("last_window", 128'(log_q[base+15].din),
              128'(pack9(11, 12, 0, 15, 16, 0, 0, 0, 0)));
          chk("last_centre", 128'({log_q[base+15].x, log_q[base+15].y}), 128'(16'h0303));
        end else begin
          for (int k = 0; k < 4; k++)
            chk("stride_centre", 128'({log_q[base+k].x, log_q[base+k].y, log_q[base+k].fd}),
                128'({8'(tx[k]), 8'(ty[k]), tf[k][0]}));
          chk("stride_last_window", 128'(log_q[base+3].din),
              128'(pack9(6, 7, 8, 10, 11, 12, 14, 15, 16)));
        end
      end

      // output back-pressure held for 10 cycles mid-frame
      if (sel == 0) begin
        n_rd_hold  = 0;
        hold_fired = 0;
        base = log_q.size();
        for (int i = 0; i < 16; i++) frame_pix[i] = int'($urandom_range(0, 255));
        push_frame();
        arm = 1;
        wait_fd(1, 400, "stall_frame");
        chk("stall_fired", 128'(hold_fired), 128'(1));
        chk("stall_reads", 128'(n_rd_hold), 128'(0));
        chk("stall_writes", 128'(log_q.size() - base), 128'(16));
      end

      // randomly starved source
      rand_empty = 1;
      n_wr_empty = 0;
      base = log_q.size();
      for (int f = 0; f < 2; f++) begin
        for (int i = 0; i < 16; i++) frame_pix[i] = int'($urandom_range(0, 255));
        push_frame();
      end
      wait_fd(2, 3000, "starved_frames");
      rand_empty = 0;
      chk("starved_writes", 128'(log_q.size() - base), 128'(2 * nwin));
      chk("starved_leftover", 128'(exp_q.size()), 128'(0));
      if (sel == 0) chk("flush_writes_while_empty", 128'(n_wr_empty >= 4), 128'(1));

      // reset 20 cycles into a frame, then a fresh frame
      for (int i = 0; i < 16; i++) frame_pix[i] = int'($urandom_range(0, 255));
      push_frame();
      tick(20);
      do_reset();
      base = log_q.size();
      for (int i = 0; i < 16; i++) frame_pix[i] = i + 1;
      push_frame();
      wait_fd(1, 400, "after_reset_frame");
      chk("after_reset_writes", 128'(log_q.size() - base), 128'(nwin));
      if (log_q.size() >= base + nwin)
        chk("after_reset_first_window", 128'(log_q[base].din),
            128'(pack9(padv, padv, padv, padv, 1, 2, padv, 5, 6)));
    end
    chk("write_while_full", 128'(n_wr_bad), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
